// File: rtl/serial_subtractor_ctrl.sv
// ---------------------------------------------------------------------------
// serial_subtractor_ctrl
//   Bit-serial N-bit subtractor: computes A - B - bin one bit per clock using
//   a single shared full-subtractor cell, which is built from two
//   half-subtractor stages. A start/done handshake frames each operation, and
//   diff/bout stay stable until the next operation completes.
//
//   Parameters
//     W      operand/result width in bits (1..32)
//
//   Ports
//     clk    clock, rising-edge
//     rst    synchronous active-high reset
//     start  request, sampled only while idle
//     a, b   minuend / subtrahend, captured on the accepted start
//     bin    borrow-in, captured on the accepted start
//     busy   high while bits are being processed
//     done   one-cycle pulse; diff/bout are valid from this cycle on
//     diff   A - B - bin modulo 2^W
//     bout   borrow-out (A < B + bin, unsigned)
//     ovf    signed overflow flag; exists only when SUB_OVERFLOW_EN is defined
//
//   Build option: `define SUB_OVERFLOW_EN adds the ovf output.
// ---------------------------------------------------------------------------

// Half subtractor: d = x - y, borrow when x=0, y=1.
module half_subtractor (
    input  logic i_x,
    input  logic i_y,
    output logic o_d,
    output logic o_b
);
    assign o_d = i_x ^ i_y;
    assign o_b = ~i_x & i_y;
endmodule

// Full subtractor from two half subtractors: (x - y) - bin.
module full_subtractor (
    input  logic i_x,
    input  logic i_y,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);
    logic w_d1, w_b1, w_b2;

    half_subtractor u_hs0 (.i_x(i_x),  .i_y(i_y),   .o_d(w_d1), .o_b(w_b1));
    half_subtractor u_hs1 (.i_x(w_d1), .i_y(i_bin), .o_d(o_d),  .o_b(w_b2));

    // The two stages can never both borrow, so OR merges them.
    assign o_bout = w_b1 | w_b2;
endmodule

module serial_subtractor_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic         ovf
`endif
);
    // Counter must be at least 1 bit wide even when W=1.
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_sa;
    logic [W-1:0]   r_sb;
    logic           r_borrow;
    logic [W-1:0]   r_res;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;
    logic [W-1:0]   r_diff;
    logic           r_bout;
`ifdef SUB_OVERFLOW_EN
    logic           r_a_msb;
    logic           r_b_msb;
    logic           r_ovf;
`endif

    logic           w_d;
    logic           w_bnext;
    logic [W-1:0]   w_res_next;
    logic           w_last;

    full_subtractor u_cell (
        .i_x    (r_sa[0]),
        .i_y    (r_sb[0]),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bnext)
    );

    // New bit enters at the MSB; after W shifts bit 0 of the result sits at
    // bit 0. Written as a shift/OR so it also holds for W=1.
    assign w_res_next = (r_res >> 1) | (W'(w_d) << (W - 1));
    assign w_last     = (r_cnt == CW'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_borrow <= 1'b0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sa     <= a;
                        r_sb     <= b;
                        r_borrow <= bin;
                        r_cnt    <= '0;
`ifdef SUB_OVERFLOW_EN
                        // Operand MSBs are shifted out during RUN; keep them.
                        r_a_msb  <= a[W-1];
                        r_b_msb  <= b[W-1];
`endif
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end

                S_RUN: begin
                    r_sa     <= r_sa >> 1;
                    r_sb     <= r_sb >> 1;
                    r_borrow <= w_bnext;
                    r_res    <= w_res_next;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        // Publish on the final processing edge so done and the
                        // result appear in the same cycle.
                        r_diff  <= w_res_next;
                        r_bout  <= w_bnext;
`ifdef SUB_OVERFLOW_EN
                        r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
`ifdef SUB_OVERFLOW_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl (W=8). Expected values come from plain
// integer arithmetic on the operands.
module tb_serial_subtractor_ctrl;
    localparam int W = 8;
    localparam int TMO = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done, bout;
    logic [W-1:0] diff;
`ifdef SUB_OVERFLOW_EN
    logic         ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    serial_subtractor_ctrl #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SUB_OVERFLOW_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: unsigned modular difference and borrow.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int unsigned t;
        t = int'(x) - int'(y) - int'(c);
        return t[W-1:0];
    endfunction

    function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return int'(x) < (int'(y) + int'(c));
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W-1:0] d;
        d = ref_diff(x, y, c);
        return (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
    endfunction

    // Runs one operation from IDLE; lat = cycles from start edge to done
    // (-1 on timeout). Leaves the DUT back in IDLE.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                          output int lat, output logic [W-1:0] od, output logic ob,
                          output logic oovf, output logic dn_after);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= TMO; c++) begin
            tick();
            if (done) begin lat = c; break; end
        end
        od = diff; ob = bout;
`ifdef SUB_OVERFLOW_EN
        oovf = ovf;
`else
        oovf = 1'b0;
`endif
        tick();
        dn_after = done;
    endtask

    task automatic test_reset();
        int lat; logic [W-1:0] d; logic bo, ov, da; int seen;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_vec++; if ({busy, done, diff, bout} !== '0) begin
            n_err++; $display("FAIL reset_state: got busy=%b done=%b diff=%h bout=%b, want all 0", busy, done, diff, bout);
        end
        run_op(8'd9, 8'd2, 1'b0, lat, d, bo, ov, da);
        n_vec++; if (d !== 8'd7) begin
            n_err++; $display("FAIL pre_reset_op: got diff=%h want 07", d);
        end
        // Reset in the middle of RUN.
        a = 8'hF0; b = 8'h0F; start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        n_vec++; if ({busy, done, diff, bout} !== '0) begin
            n_err++; $display("FAIL reset_midrun: got busy=%b done=%b diff=%h bout=%b, want all 0", busy, done, diff, bout);
        end
        seen = 0;
        for (int c = 0; c < 2 * W + 4; c++) begin tick(); if (done || busy) seen++; end
        n_vec++; if (seen !== 0) begin
            n_err++; $display("FAIL reset_no_done: got %0d busy/done cycles, want 0", seen);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] old_d;
        int bad;
        old_d = diff; bad = 0;
        a = 8'd5; b = 8'd3; bin = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (busy !== 1'b1 || done !== 1'b0 || diff !== old_d) bad++;
            if (i < W - 1) tick();
        end
        n_vec++; if (bad !== 0) begin
            n_err++; $display("FAIL basic_run_window: got %0d bad cycles, want 0 (busy=1, done=0, diff held)", bad);
        end
        tick();
        n_vec++; if (done !== 1'b1 || busy !== 1'b0 || diff !== 8'h02 || bout !== 1'b0) begin
            n_err++; $display("FAIL basic_done: got done=%b busy=%b diff=%h bout=%b want 1 0 02 0", done, busy, diff, bout);
        end
        tick();
        n_vec++; if (done !== 1'b0 || diff !== 8'h02) begin
            n_err++; $display("FAIL basic_pulse: got done=%b diff=%h want 0 02", done, diff);
        end
    endtask

    task automatic test_underflow();
        int lat; logic [W-1:0] d; logic bo, ov, da;
        run_op(8'h00, 8'h01, 1'b0, lat, d, bo, ov, da);
        n_vec++; if (d !== 8'hFF || bo !== 1'b1 || lat !== W) begin
            n_err++; $display("FAIL underflow_0m1: got diff=%h bout=%b lat=%0d want ff 1 %0d", d, bo, lat, W);
        end
        run_op(8'h10, 8'h0F, 1'b1, lat, d, bo, ov, da);
        n_vec++; if (d !== 8'h00 || bo !== 1'b0) begin
            n_err++; $display("FAIL underflow_bin: got diff=%h bout=%b want 00 0", d, bo);
        end
    endtask

    task automatic test_ignored_start();
        int first, second, cnt;
        logic [W-1:0] d1;
        first = -1; second = -1; cnt = 0; d1 = '0;
        a = 8'hAA; b = 8'h55; bin = 1'b0; start = 1'b1;
        tick();
        for (int c = 1; c <= 2 * W + 3; c++) begin
            tick();
            if (done) begin
                cnt++;
                if (first < 0) begin first = c; d1 = diff; end
                else second = c;
            end
        end
        start = 1'b0;
        n_vec++; if (first !== W || second !== 2 * W + 2 || cnt !== 2) begin
            n_err++; $display("FAIL hold_start_timing: got dones at %0d,%0d (n=%0d) want %0d,%0d (n=2)", first, second, cnt, W, 2 * W + 2);
        end
        n_vec++; if (d1 !== 8'h55 || diff !== 8'h55 || bout !== 1'b0) begin
            n_err++; $display("FAIL hold_start_result: got diff=%h/%h bout=%b want 55 0", d1, diff, bout);
        end
        // Start pulses during RUN and DONE must not spawn another operation.
        a = 8'h30; b = 8'h10; start = 1'b1; tick(); start = 1'b0;
        cnt = 0;
        for (int c = 1; c <= 3 * W; c++) begin
            start = (c == 2 || c == 5 || c == W + 1);
            tick();
            if (done) cnt++;
        end
        start = 1'b0;
        n_vec++; if (cnt !== 1 || diff !== 8'h20 || busy !== 1'b0) begin
            n_err++; $display("FAIL run_pulses: got dones=%0d diff=%h busy=%b want 1 20 0", cnt, diff, busy);
        end
    endtask

    task automatic test_isolation();
        int lat;
        a = 8'd200; b = 8'd100; bin = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        lat = -1;
        for (int c = 1; c <= TMO; c++) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            tick();
            if (done) begin lat = c; break; end
        end
        n_vec++; if (lat !== W || diff !== 8'd100 || bout !== 1'b0) begin
            n_err++; $display("FAIL isolation: got lat=%0d diff=%0d bout=%b want %0d 100 0", lat, diff, bout, W);
        end
        tick();
    endtask

    task automatic test_random();
        int lat; logic [W-1:0] x, y, d; logic c, bo, ov, da;
        for (int i = 0; i < 40; i++) begin
            x = W'($urandom); y = W'($urandom); c = 1'($urandom);
            if (i == 0) begin x = '0; y = '1; c = 1'b1; end
            if (i == 1) begin x = '1; y = '0; c = 1'b0; end
            run_op(x, y, c, lat, d, bo, ov, da);
            n_vec++;
            if (d !== ref_diff(x, y, c) || bo !== ref_bout(x, y, c) || lat !== W || da !== 1'b0
`ifdef SUB_OVERFLOW_EN
                || ov !== ref_ovf(x, y, c)
`endif
            ) begin
                n_err++;
                $display("FAIL random[%0d] %h-%h-%b: got diff=%h bout=%b ovf=%b lat=%0d done_after=%b want %h %b %b %0d 0",
                         i, x, y, c, d, bo, ov, lat, da, ref_diff(x, y, c), ref_bout(x, y, c), ref_ovf(x, y, c), W);
            end
        end
    endtask

`ifdef SUB_OVERFLOW_EN
    task automatic test_overflow();
        int lat; logic [W-1:0] d; logic bo, ov, da;
        run_op(8'h80, 8'h01, 1'b0, lat, d, bo, ov, da);
        n_vec++; if (d !== 8'h7F || bo !== 1'b0 || ov !== 1'b1) begin
            n_err++; $display("FAIL ovf_set: got diff=%h bout=%b ovf=%b want 7f 0 1", d, bo, ov);
        end
        run_op(8'h7F, 8'h01, 1'b0, lat, d, bo, ov, da);
        n_vec++; if (d !== 8'h7E || ov !== 1'b0) begin
            n_err++; $display("FAIL ovf_clear: got diff=%h ovf=%b want 7e 0", d, ov);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_ignored_start();
        test_isolation();
        test_random();
`ifdef SUB_OVERFLOW_EN
        test_overflow();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
